sa_port_sched3: RTL and testbench

- Per-output-port switch scheduler for the 3-port router slice (Local, North, East).
- Arbitrates round-robin among the three input buffers that target this output port.
- Replaces the downstream full flag with credit-based flow control.
- Drives a one-flit registered output stage.
- One instance sits on each output port, beside the switch allocator. The allocator decodes input labels into this block's request vector.

---
 rtl/sa_port_sched3.sv | 109 ++++++++++
 tb/tb_sa_port_sched3.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sa_port_sched3.sv
// Per-output-port switch scheduler: round-robin over L/N/E requesters,
// credit-based downstream flow control and a one-flit registered output stage.
module sa_port_sched3 #(
    parameter int DATASIZE = 40,
    parameter int CREDITS  = 8,
    parameter int CWIDTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          req,
    input  logic [DATASIZE-1:0] L_data_in,
    input  logic [DATASIZE-1:0] N_data_in,
    input  logic [DATASIZE-1:0] E_data_in,
    input  logic                credit_in,
    output logic [2:0]          grant,
    output logic [DATASIZE-1:0] data_out,
    output logic                data_valid,
    output logic [CWIDTH-1:0]   credit_cnt,
    output logic                credit_err
);

    localparam logic [CWIDTH-1:0] CMAX = CWIDTH'(CREDITS);

    logic [2:0]          ptr_q, ptr_d;
    logic [CWIDTH-1:0]   cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                vld_q, vld_d;

    // First requester found scanning from the pointer, wrapping L->N->E->L.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [2:0] p);
        logic [2:0] g;
        g = 3'b000;
        case (p)
            3'b010: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            3'b100: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    // A credit arriving this cycle only counts from the next cycle on.
    always_comb begin
        grant = 3'b000;
        if (rst_n && (cnt_q != '0)) begin
            grant = rr_pick(req, ptr_q);
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        dout_d = dout_q;
        vld_d  = |grant;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (|grant) begin
            ptr_d = {grant[1:0], grant[2]};
            case (grant)
                3'b010:  dout_d = N_data_in;
                3'b100:  dout_d = E_data_in;
                default: dout_d = L_data_in;
            endcase
        end
        if ((|grant) && !credit_in) begin
            cnt_d = cnt_q - CWIDTH'(1);
        end else if (!(|grant) && credit_in) begin
            // Surplus credit: hold at the maximum and flag it permanently.
            if (cnt_q == CMAX) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 3'b001;
            cnt_q  <= CMAX;
            err_q  <= 1'b0;
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = vld_q;
    assign credit_cnt = cnt_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_sa_port_sched3.sv
// Directed bench for sa_port_sched3: table-driven vectors plus hand sequences
// for credit exhaustion, overflow and asynchronous reset.
module tb_sa_port_sched3;

    localparam logic [39:0] LD = 40'hA0_0000_0011;
    localparam logic [39:0] ND = 40'hB0_0000_0022;
    localparam logic [39:0] ED = 40'hC0_0000_0033;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [39:0] L_data_in, N_data_in, E_data_in;
    logic        credit_in;
    logic [2:0]  grant;
    logic [39:0] data_out;
    logic        data_valid;
    logic [3:0]  credit_cnt;
    logic        credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    sa_port_sched3 #(.DATASIZE(40), .CREDITS(8), .CWIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .L_data_in(L_data_in), .N_data_in(N_data_in), .E_data_in(E_data_in),
        .credit_in(credit_in), .grant(grant), .data_out(data_out),
        .data_valid(data_valid), .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic        cin;
        logic [2:0]  eg;
        logic        ev;
        logic [3:0]  ec;
        logic        ee;
        logic [39:0] ed;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive at negedge, check combinational grant mid-cycle, registered outputs after the edge.
    task automatic step(input logic [2:0] r, input logic ci, input logic [2:0] eg,
                        input logic ev, input logic [3:0] ec, input logic ee,
                        input logic [39:0] ed, input string nm);
        @(negedge clk);
        req = r;
        credit_in = ci;
        #1;
        chk({nm, " grant"}, 64'(grant), 64'(eg));
        if (grant != 3'b000) chk({nm, " no_grant_at_zero"}, 64'(credit_cnt != 4'd0), 64'd1);
        @(posedge clk);
        #1;
        chk({nm, " data_valid"}, 64'(data_valid), 64'(ev));
        chk({nm, " credit_cnt"}, 64'(credit_cnt), 64'(ec));
        chk({nm, " credit_err"}, 64'(credit_err), 64'(ee));
        if (ev) chk({nm, " data_out"}, data_out[39:0], ed);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 3'b000;
        credit_in = 1'b0;
        L_data_in = LD;
        N_data_in = ND;
        E_data_in = ED;

        // Idle vectors, then full contention with a returning credit each cycle.
        for (int i = 0; i < 5; i++) tbl.push_back('{3'b000, 1'b0, 3'b000, 1'b0, 4'd8, 1'b0, 40'd0});
        tbl.push_back('{3'b111, 1'b1, 3'b001, 1'b1, 4'd8, 1'b0, LD});
        tbl.push_back('{3'b111, 1'b1, 3'b010, 1'b1, 4'd8, 1'b0, ND});
        tbl.push_back('{3'b111, 1'b1, 3'b100, 1'b1, 4'd8, 1'b0, ED});
        tbl.push_back('{3'b111, 1'b1, 3'b001, 1'b1, 4'd8, 1'b0, LD});
        tbl.push_back('{3'b111, 1'b1, 3'b010, 1'b1, 4'd8, 1'b0, ND});
        tbl.push_back('{3'b111, 1'b1, 3'b100, 1'b1, 4'd8, 1'b0, ED});
        tbl.push_back('{3'b000, 1'b0, 3'b000, 1'b0, 4'd8, 1'b0, 40'd0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset grant", 64'(grant), 64'd0);
        chk("reset credit_cnt", 64'(credit_cnt), 64'd8);
        chk("reset data_valid", 64'(data_valid), 64'd0);
        chk("reset data_out", data_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].cin, tbl[i].eg, tbl[i].ev, tbl[i].ec, tbl[i].ee,
                 tbl[i].ed, $sformatf("tbl[%0d]", i));
        end

        // Drain all credits with a single requester.
        for (int k = 1; k <= 8; k++) begin
            step(3'b001, 1'b0, 3'b001, 1'b1, 4'(8 - k), 1'b0, LD, $sformatf("burst%0d", k));
        end
        step(3'b001, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 40'd0, "empty");
        step(3'b001, 1'b1, 3'b000, 1'b0, 4'd1, 1'b0, 40'd0, "credit_at_zero");
        step(3'b001, 1'b0, 3'b001, 1'b1, 4'd0, 1'b0, LD, "grant_after_credit");
        step(3'b001, 1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 40'd0, "empty_again");

        // Refill to 3, then grant and credit together.
        for (int k = 1; k <= 3; k++) begin
            step(3'b000, 1'b1, 3'b000, 1'b0, 4'(k), 1'b0, 40'd0, $sformatf("refill%0d", k));
        end
        step(3'b010, 1'b1, 3'b010, 1'b1, 4'd3, 1'b0, ND, "grant_and_credit");

        // Fill to the maximum, then one credit too many.
        for (int k = 4; k <= 8; k++) begin
            step(3'b000, 1'b1, 3'b000, 1'b0, 4'(k), 1'b0, 40'd0, $sformatf("fill%0d", k));
        end
        step(3'b000, 1'b1, 3'b000, 1'b0, 4'd8, 1'b1, 40'd0, "overflow");
        step(3'b000, 1'b0, 3'b000, 1'b0, 4'd8, 1'b1, 40'd0, "err_sticky1");
        step(3'b000, 1'b0, 3'b000, 1'b0, 4'd8, 1'b1, 40'd0, "err_sticky2");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset clears credit_err", 64'(credit_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-burst asynchronous reset with the pointer parked at N.
        step(3'b001, 1'b0, 3'b001, 1'b1, 4'd7, 1'b0, LD, "pre_rst1");
        step(3'b001, 1'b0, 3'b001, 1'b1, 4'd6, 1'b0, LD, "pre_rst2");
        step(3'b001, 1'b0, 3'b001, 1'b1, 4'd5, 1'b0, LD, "pre_rst3");
        req = 3'b111;
        rst_n = 1'b0;
        #1;
        chk("midrst data_valid", 64'(data_valid), 64'd0);
        chk("midrst credit_cnt", 64'(credit_cnt), 64'd8);
        chk("midrst grant", 64'(grant), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst grant", 64'(grant), 64'b001);
        @(posedge clk);
        #1;
        chk("post_rst data_valid", 64'(data_valid), 64'd1);
        chk("post_rst data_out", data_out, 64'(LD));
        chk("post_rst credit_cnt", 64'(credit_cnt), 64'd7);
        req = 3'b000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
